alu8_sequencer: RTL
===================

# alu8_sequencer

Sequencer that owns the 8-bit ALU's control and operand ports, driving one ALU pass per request for byte operations and two chained passes for 16-bit operations. Sits between the CPU control unit and the ALU instance: accepts a start/busy/done request, latches operands, steps the ALU through its compute and bus-read phases, and returns a captured 16-bit result with a full-width zero flag.

## Interface
- No parameters; widths fixed at 16-bit request, 8-bit ALU.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request strobe, sampled only in IDLE.
- `op` in 4: operator code from `cpu_data.v` (`OP_*`).
- `single` in 1: unary operator select, forwarded to the ALU.
- `wide` in 1: 1 = 16-bit operation, 0 = 8-bit (low bytes only).
- `a`, `b` in 16: operands; `a` is value1, `b` is value2.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `result` out 16: captured result, held until the next completion.
- `zero` out 1: 1 when the captured result is zero at the operation width.
- `error` out 1: unsupported wide operator; valid with `done`.
- `alu_cs_in`, `alu_cs_out`, `alu_single` out 1: ALU controls.
- `alu_operator` out 4: ALU operator.
- `alu_value1`, `alu_value2` out 8: ALU operands.
- `alu_bus` in 8: ALU result bus.

## Operation
- States: IDLE, EXEC_A, READ_A, EXEC_B, READ_B, FIN.
- IDLE with `start`=1: latch `op`, `single`, `wide`, `a`, `b`.
  - Narrow requests go to EXEC_A.
  - Supported wide requests go to EXEC_A.
  - Unsupported wide requests go to FIN with the error flag set.
- EXEC_A / EXEC_B: `alu_cs_in`=1 for exactly one cycle, with operator and operand bytes driven.
- READ_A / READ_B: `alu_cs_out`=1; `alu_bus` is captured into the pass's result byte at the end of the cycle.
- READ_A goes to EXEC_B if wide, else to FIN. READ_B goes to FIN. FIN goes to IDLE.
- Narrow pass A uses `op` on `a[7:0]` / `b[7:0]`. `result[15:8]` is set to 0.
- Wide pass mapping (pass A first), bytes lo/hi:
  - ADD → ADD(lo), ADC(hi).
  - SUB and CMP → op(lo), SBC(hi).
  - ADC → ADC(lo), ADC(hi).
  - SBC → SBC(lo), SBC(hi).
  - AND/OR/XOR/MOV → op(lo), op(hi).
  - LSL → LSL(lo), RLC(hi).
  - LSR → LSR(hi), RRC(lo). Pass A writes the high result byte.
- All other wide operators are unsupported: `error`=1, no ALU activity.
- CMP still updates `result` with the difference.
- `zero` is computed by the sequencer from the captured result: `result==0` (wide) or `result[7:0]==0` (narrow). It is not derived from the ALU's internal flag.
- `alu_single` equals the latched `single`; wide unary shifts force it to 1.
- Outside EXEC/READ states, `alu_cs_in`=`alu_cs_out`=0, and `alu_operator` and the values hold their last driven value.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `error`, `zero`, `alu_cs_in`, `alu_cs_out`, `alu_single` = 0.
  - `result`=0, `alu_operator`=0, `alu_value1`=`alu_value2`=0.
- Start accepted at edge n. Then:
  - Narrow: EXEC_A in cycle n+1, READ_A in n+2, FIN (`done`=1) in n+3.
  - Wide: `done` in n+5.
  - Error: `done`=`error`=1 in n+1.
- `result`, `zero` and `error` are valid from the FIN cycle and held through IDLE. `error` clears on the next accepted start.
- `start` while busy is ignored, with no queuing. `start` in FIN is ignored; a new request is accepted in IDLE only.
- `rst` mid-operation: IDLE on the next edge.
  - No `done` pulse.
  - `result` cleared to 0.
  - The ALU carry flag is not reset (the ALU has no reset), so a following narrow ADC/SBC sees a stale carry.
- Operand inputs may change after the accept edge without effect.

## Test plan
- Wide ADD `a`=0x12FF, `b`=0x0001 → `result`=0x1300, `zero`=0, `done` exactly 5 cycles after the accept edge, `busy` high in cycles n+1..n+5.
- Wide SUB 0x0100−0x0001 → 0x00FF. Then wide CMP 0x1234 vs 0x1234 → `result`=0x0000, `zero`=1.
- Wide LSR `a`=0x8001 → `result`=0x4000. Check the ALU sees LSR on 0x80 before RRC on 0x01.
- Narrow AND `a`=0x55F0, `b`=0xAA0F → `result`=0x0000, `zero`=1, `done` at n+3, exactly one `alu_cs_in` pulse.
- Wide NEG → `done`=`error`=1 at n+1, `alu_cs_in` never asserted, `result` unchanged.
- Assert `rst` during EXEC_B of a wide ADD → IDLE next cycle, no `done`, `result`=0. Also check that `start` pulses while busy are dropped.

Source files
------------

// File: rtl/alu8_sequencer.sv
// alu8_sequencer: steps an external 8-bit ALU through one pass for byte requests or two
// chained passes for 16-bit requests, returning a captured 16-bit result and zero flag.
module alu8_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic        single,
    input  logic        wide,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        zero,
    output logic        error,
    output logic        alu_cs_in,
    output logic        alu_cs_out,
    output logic        alu_single,
    output logic [3:0]  alu_operator,
    output logic [7:0]  alu_value1,
    output logic [7:0]  alu_value2,
    input  logic [7:0]  alu_bus
);
    localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_MOV = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8,  OP_LSL = 4'd9,  OP_LSR = 4'd10, OP_RLC = 4'd11;
    localparam logic [3:0] OP_RRC = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXEC_A = 3'd1,
        S_READ_A = 3'd2,
        S_EXEC_B = 3'd3,
        S_READ_B = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic        wide_q, wide_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [7:0]  tmp_q, tmp_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [15:0] result_q, result_d;
    logic        zero_q, zero_d, error_q, error_d;
    logic        cs_in_q, cs_in_d, cs_out_q, cs_out_d;
    logic        alu_single_q, alu_single_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [7:0]  value1_q, value1_d, value2_q, value2_d;
    logic [15:0] wide_res_s;
    logic [19:0] cfg_s;

    function automatic logic wide_ok(input logic [3:0] o);
        logic ok;
        case (o)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR,
            OP_XOR, OP_MOV, OP_CMP, OP_LSL, OP_LSR: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Returns {operator, value1, value2} for a pass; LSR walks high byte first so the
    // shifted-out bit reaches the low byte through the carry.
    function automatic logic [19:0] pass_cfg(input logic [3:0] o, input logic w,
                                             input logic second_pass,
                                             input logic [15:0] x, input logic [15:0] y);
        logic [19:0] lo_cfg, hi_cfg, cfg;
        lo_cfg = {o, x[7:0], y[7:0]};
        hi_cfg = {o, x[15:8], y[15:8]};
        if (!w) begin
            cfg = lo_cfg;
        end else begin
            case (o)
                OP_ADD:         cfg = second_pass ? {OP_ADC, x[15:8], y[15:8]} : lo_cfg;
                OP_SUB, OP_CMP: cfg = second_pass ? {OP_SBC, x[15:8], y[15:8]} : lo_cfg;
                OP_LSL:         cfg = second_pass ? {OP_RLC, x[15:8], y[15:8]} : lo_cfg;
                OP_LSR:         cfg = second_pass ? {OP_RRC, x[7:0], y[7:0]}
                                                  : {OP_LSR, x[15:8], y[15:8]};
                default:        cfg = second_pass ? hi_cfg : lo_cfg;
            endcase
        end
        return cfg;
    endfunction

    // Next-state, operand latching, result capture and registered output decode
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wide_d       = wide_q;
        a_d          = a_q;
        b_d          = b_q;
        tmp_d        = tmp_q;
        result_d     = result_q;
        zero_d       = zero_q;
        error_d      = error_q;
        alu_single_d = alu_single_q;
        alu_op_d     = alu_op_q;
        value1_d     = value1_q;
        value2_d     = value2_q;
        cfg_s        = 20'h00000;
        wide_res_s   = (op_q == OP_LSR) ? {tmp_q, alu_bus} : {alu_bus, tmp_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d         = op;
                    wide_d       = wide;
                    a_d          = a;
                    b_d          = b;
                    error_d      = 1'b0;
                    alu_single_d = single | (wide & ((op == OP_LSL) || (op == OP_LSR)));
                    if (wide && !wide_ok(op)) begin
                        error_d = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_EXEC_A;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC_A: state_d = S_READ_A;
            S_READ_A: begin
                if (wide_q) begin
                    tmp_d   = alu_bus;
                    state_d = S_EXEC_B;
                end else begin
                    result_d = {8'h00, alu_bus};
                    zero_d   = (alu_bus == 8'h00);
                    state_d  = S_FIN;
                end
            end
            S_EXEC_B: state_d = S_READ_B;
            S_READ_B: begin
                result_d = wide_res_s;
                zero_d   = (wide_res_s == 16'h0000);
                state_d  = S_FIN;
            end
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (state_d == S_EXEC_A) begin
            cfg_s = pass_cfg(op, wide, 1'b0, a, b);
            {alu_op_d, value1_d, value2_d} = cfg_s;
        end else if (state_d == S_EXEC_B) begin
            cfg_s = pass_cfg(op_q, wide_q, 1'b1, a_q, b_q);
            {alu_op_d, value1_d, value2_d} = cfg_s;
        end else begin
            cfg_s = 20'h00000;
        end

        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_FIN);
        cs_in_d  = (state_d == S_EXEC_A) || (state_d == S_EXEC_B);
        cs_out_d = (state_d == S_READ_A) || (state_d == S_READ_B);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 4'h0;
            wide_q       <= 1'b0;
            a_q          <= 16'h0000;
            b_q          <= 16'h0000;
            tmp_q        <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= 16'h0000;
            zero_q       <= 1'b0;
            error_q      <= 1'b0;
            cs_in_q      <= 1'b0;
            cs_out_q     <= 1'b0;
            alu_single_q <= 1'b0;
            alu_op_q     <= 4'h0;
            value1_q     <= 8'h00;
            value2_q     <= 8'h00;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            wide_q       <= wide_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tmp_q        <= tmp_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            error_q      <= error_d;
            cs_in_q      <= cs_in_d;
            cs_out_q     <= cs_out_d;
            alu_single_q <= alu_single_d;
            alu_op_q     <= alu_op_d;
            value1_q     <= value1_d;
            value2_q     <= value2_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign zero         = zero_q;
    assign error        = error_q;
    assign alu_cs_in    = cs_in_q;
    assign alu_cs_out   = cs_out_q;
    assign alu_single   = alu_single_q;
    assign alu_operator = alu_op_q;
    assign alu_value1   = value1_q;
    assign alu_value2   = value2_q;
endmodule
